// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into single-cycle press/release/short/long/double-click pulses.
// Optional auto-repeat while held past a long press is enabled by defining AUTO_REPEAT_EN.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | button released, no sequence in progress
// S_PRESSED   | first press held, timing towards long press
// S_LONG_HELD | long press reported, waiting for release (repeats if enabled)
// S_WAIT_DC   | short press released, waiting for a second press in window
// S_SECOND    | second press of a double click held, waiting for release
module button_event_decoder #(
   parameter int  SYSCLK_FREQ         = 24000000,
   parameter real LONG_PRESS_DELAY    = 0.500,
   parameter real DOUBLE_CLICK_WINDOW = 0.250,
   parameter real REPEAT_PERIOD       = 0.100
) (
   input  logic clk,
   input  logic rst_n,
   input  logic db_in,
   output logic held,
   output logic press_pulse,
   output logic release_pulse,
   output logic short_press,
   output logic long_press,
   output logic double_click,
   output logic repeat_pulse
);

   localparam int LONG_CNT = int'(real'(SYSCLK_FREQ) * LONG_PRESS_DELAY);
   localparam int DC_CNT   = int'(real'(SYSCLK_FREQ) * DOUBLE_CLICK_WINDOW);
   localparam bit DC_EN    = (DC_CNT > 0);
   localparam int CNT_MAX  = (LONG_CNT > DC_CNT) ? LONG_CNT : DC_CNT;
   localparam int CW       = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] LONG_TC = CW'(LONG_CNT - 1);
   localparam logic [CW-1:0] DC_TC   = DC_EN ? CW'(DC_CNT - 1) : '0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRESSED,
      S_LONG_HELD,
      S_WAIT_DC,
      S_SECOND
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic          db_q;
   logic          rise, fall;
   logic          short_nx, long_nx, dc_nx;

   assign rise = db_in & ~db_q;
   assign fall = ~db_in & db_q;

   always_comb begin
      state_nx = state;
      short_nx = 1'b0;
      long_nx  = 1'b0;
      dc_nx    = 1'b0;
      case (state)
         S_IDLE: begin
            if (rise) state_nx = S_PRESSED;
         end
         S_PRESSED: begin
            if (fall) begin
               if (DC_EN) begin
                  state_nx = S_WAIT_DC;
               end else begin
                  state_nx = S_IDLE;
                  short_nx = 1'b1;
               end
            end else if (db_in && (cnt == LONG_TC)) begin
               state_nx = S_LONG_HELD;
               long_nx  = 1'b1;
            end
         end
         S_LONG_HELD: begin
            if (fall) state_nx = S_IDLE;
         end
         S_WAIT_DC: begin
            // a second press on the timeout cycle still counts as a double click
            if (rise) begin
               state_nx = S_SECOND;
               dc_nx    = 1'b1;
            end else if (cnt == DC_TC) begin
               state_nx = S_IDLE;
               short_nx = 1'b1;
            end
         end
         S_SECOND: begin
            if (fall) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         cnt           <= '0;
         db_q          <= 1'b0;
         held          <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         short_press   <= 1'b0;
         long_press    <= 1'b0;
         double_click  <= 1'b0;
      end else begin
         state         <= state_nx;
         db_q          <= db_in;
         held          <= db_in;
         press_pulse   <= rise;
         release_pulse <= fall;
         short_press   <= short_nx;
         long_press    <= long_nx;
         double_click  <= dc_nx;
         if (state_nx != state) begin
            cnt <= '0;
         end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

`ifdef AUTO_REPEAT_EN
   localparam int REP_CNT = int'(real'(SYSCLK_FREQ) * REPEAT_PERIOD);
   localparam int RW      = (REP_CNT < 1) ? 1 : $clog2(REP_CNT + 1);
   localparam logic [RW-1:0] REP_TC = (REP_CNT > 0) ? RW'(REP_CNT - 1) : '0;

   logic [RW-1:0] rep_cnt;
   logic          rep_hit;

   // db_in low here means a fall on the terminal cycle, which suppresses the repeat
   assign rep_hit = (state == S_LONG_HELD) && db_in && (rep_cnt == REP_TC);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_cnt      <= '0;
         repeat_pulse <= 1'b0;
      end else begin
         repeat_pulse <= rep_hit;
         if ((state != S_LONG_HELD) || (state_nx != S_LONG_HELD) || rep_hit) begin
            rep_cnt <= '0;
         end else if (rep_cnt != '1) begin
            rep_cnt <= rep_cnt + 1'b1;
         end
      end
   end
`else
   assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Randomized and directed bench for button_event_decoder against a timestamp-based event model.
// Expected repeat behaviour follows AUTO_REPEAT_EN as defined for the build.
module tb_button_event_decoder;

   localparam int LONG_CNT = 100;
   localparam int DC_CNT   = 50;
   localparam int REP_CNT  = 20;

   logic clk = 1'b0;
   logic rst_n;
   logic db_in;
   logic held, press_pulse, release_pulse, short_press, long_press, double_click, repeat_pulse;

   button_event_decoder #(
      .SYSCLK_FREQ         (1000000),
      .LONG_PRESS_DELAY    (0.0001),
      .DOUBLE_CLICK_WINDOW (0.00005),
      .REPEAT_PERIOD       (0.00002)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .db_in         (db_in),
      .held          (held),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .short_press   (short_press),
      .long_press    (long_press),
      .double_click  (double_click),
      .repeat_pulse  (repeat_pulse)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Event model: works from timestamps of rises and falls, not from a state machine.
   int   t = 0;
   logic m_prev = 1'b0;
   int   cur_start = 0;
   bit   cur_second = 0, cur_long = 0, pending = 0;
   int   pend_fall = 0;
   int   e_held, e_press, e_rel, e_short, e_long, e_dc, e_rep;

   task automatic model_edge(input logic d, input logic rn);
      logic rise, fall;
      int   since_long;
      e_held = 0; e_press = 0; e_rel = 0; e_short = 0; e_long = 0; e_dc = 0; e_rep = 0;
      if (!rn) begin
         m_prev = 1'b0; pending = 0; cur_second = 0; cur_long = 0;
      end else begin
         rise   = d & ~m_prev;
         fall   = ~d & m_prev;
         e_held = int'(d);
         e_press = int'(rise);
         e_rel   = int'(fall);
         if (rise) begin
            if (pending && (t - pend_fall) <= DC_CNT) begin
               e_dc = 1;
               cur_second = 1;
            end else begin
               cur_second = 0;
            end
            pending = 0; cur_long = 0; cur_start = t;
         end else if (pending && (t - pend_fall) == DC_CNT) begin
            e_short = 1;
            pending = 0;
         end
         if (d && !rise && !cur_second && !cur_long && (t - cur_start) == LONG_CNT) begin
            e_long = 1;
            cur_long = 1;
         end else if (d && cur_long) begin
            since_long = t - cur_start - LONG_CNT;
`ifdef AUTO_REPEAT_EN
            if (since_long > 0 && (since_long % REP_CNT) == 0) e_rep = 1;
`else
            if (since_long < 0) e_rep = 1;
`endif
         end
         if (fall) begin
            if (!cur_second && !cur_long) begin
               pending = 1;
               pend_fall = t;
            end
            cur_second = 0; cur_long = 0;
         end
         m_prev = d;
         t++;
      end
   endtask

   int cyc = 0;
   int c_press, c_rel, c_short, c_long, c_dc, c_rep;
   int at_press, at_rel, at_short, at_long;

   task automatic sc_clear();
      c_press = 0; c_rel = 0; c_short = 0; c_long = 0; c_dc = 0; c_rep = 0;
      at_press = -1; at_rel = -1; at_short = -1; at_long = -1;
   endtask

   // Called at a negedge: drive, take one active edge, then check at the following negedge.
   task automatic cycle(input logic d);
      db_in = d;
      @(posedge clk);
      model_edge(d, rst_n);
      @(negedge clk);
      cyc++;
      check_val("held",          int'(held),          e_held);
      check_val("press_pulse",   int'(press_pulse),   e_press);
      check_val("release_pulse", int'(release_pulse), e_rel);
      check_val("short_press",   int'(short_press),   e_short);
      check_val("long_press",    int'(long_press),    e_long);
      check_val("double_click",  int'(double_click),  e_dc);
      check_val("repeat_pulse",  int'(repeat_pulse),  e_rep);
      if (press_pulse)   begin c_press++; at_press = cyc; end
      if (release_pulse) begin c_rel++;   at_rel   = cyc; end
      if (short_press)   begin c_short++; at_short = cyc; end
      if (long_press)    begin c_long++;  at_long  = cyc; end
      if (double_click)  c_dc++;
      if (repeat_pulse)  c_rep++;
   endtask

   task automatic run(input logic d, input int n);
      for (int i = 0; i < n; i++) cycle(d);
   endtask

   initial begin
      int hi, lo;
      rst_n = 1'b0;
      db_in = 1'b0;
      sc_clear();
      @(negedge clk);
      run(1'b0, 3);
      check_val("rst_held",  int'(held), 0);
      check_val("rst_press", int'(press_pulse), 0);
      check_val("rst_long",  int'(long_press), 0);
      check_val("rst_rep",   int'(repeat_pulse), 0);
      rst_n = 1'b1;
      run(1'b0, 10);

      // short press
      sc_clear();
      run(1'b1, 30); run(1'b0, 60);
      check_val("s1_press", c_press, 1);
      check_val("s1_rel",   c_rel, 1);
      check_val("s1_short", c_short, 1);
      check_val("s1_long",  c_long, 0);
      check_val("s1_dc",    c_dc, 0);
      check_val("s1_short_delay", at_short - at_rel, DC_CNT);

      // long press
      sc_clear();
      run(1'b1, 150); run(1'b0, 60);
      check_val("s2_long",  c_long, 1);
      check_val("s2_short", c_short, 0);
      check_val("s2_rel",   c_rel, 1);
      check_val("s2_long_delay", at_long - at_press, LONG_CNT);

      // double click
      sc_clear();
      run(1'b1, 20); run(1'b0, 30); run(1'b1, 20); run(1'b0, 60);
      check_val("s3_dc",    c_dc, 1);
      check_val("s3_press", c_press, 2);
      check_val("s3_rel",   c_rel, 2);
      check_val("s3_short", c_short, 0);

      // second press on the last window cycle, then one cycle late
      sc_clear();
      run(1'b1, 20); run(1'b0, DC_CNT); run(1'b1, 20); run(1'b0, 60);
      check_val("s4_dc",    c_dc, 1);
      check_val("s4_short", c_short, 0);
      sc_clear();
      run(1'b1, 20); run(1'b0, DC_CNT + 1); run(1'b1, 20); run(1'b0, 60);
      check_val("s4b_dc",    c_dc, 0);
      check_val("s4b_short", c_short, 2);

      // long hold with repeats
      sc_clear();
      run(1'b1, 200); run(1'b0, 60);
      check_val("s5_long", c_long, 1);
`ifdef AUTO_REPEAT_EN
      check_val("s5_rep", c_rep, 4);
`else
      check_val("s5_rep", c_rep, 0);
`endif

      // reset in the middle of a press, button still held afterwards
      run(1'b1, 40);
      sc_clear();
      rst_n = 1'b0;
      #1;
      check_val("s6_rst_held",  int'(held), 0);
      check_val("s6_rst_press", int'(press_pulse), 0);
      run(1'b1, 5);
      check_val("s6_rst_pulses", c_press + c_rel + c_short + c_long + c_dc + c_rep, 0);
      rst_n = 1'b1;
      cycle(1'b1);
      check_val("s6_press_after_rst", int'(press_pulse), 1);
      run(1'b1, 30); run(1'b0, 60);
      check_val("s6_press", c_press, 1);
      check_val("s6_short", c_short, 1);
      check_val("s6_long",  c_long, 0);

      // randomized runs around the long and window boundaries
      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 3))
            0:       hi = int'($urandom_range(1, 40));
            1:       hi = LONG_CNT - 1 + int'($urandom_range(0, 2));
            2:       hi = int'($urandom_range(100, 180));
            default: hi = int'($urandom_range(5, 60));
         endcase
         case ($urandom_range(0, 3))
            0:       lo = int'($urandom_range(1, 48));
            1:       lo = DC_CNT - 1 + int'($urandom_range(0, 2));
            2:       lo = int'($urandom_range(52, 90));
            default: lo = int'($urandom_range(10, 60));
         endcase
         run(1'b1, hi);
         run(1'b0, lo);
      end
      run(1'b0, 60);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
